// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical pixel counters with
// registered sync, visible-region, line-end and frame-start flags.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [10:0] count_rgb,
  output logic [9:0]  reset_count_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        line_end,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [1:0]  rst_sync_q, rst_sync_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_on_q, video_on_d;
  logic        line_end_q, line_end_d;
  logic        frame_start_q, frame_start_d;
  logic        run_ok;
  logic        advance;

  // Reset release is retimed through two flops so the FSM never leaves IDLE
  // on an edge that races the falling reset.
  assign rst_sync_d = {rst_sync_q[0], 1'b0};
  assign run_ok     = ~rst_sync_q[1];

  // NOTE: every comb output gets a default first (hold), so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    line_end_d    = line_end_q;
    frame_start_d = frame_start_q;
    advance       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pix_en && run_ok) begin
          state_d = RUN;
          h_cnt_d = '0;
          v_cnt_d = '0;
          advance = 1'b1;
        end
      end
      RUN: begin
        if (pix_en) begin
          advance = 1'b1;
          if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
              v_cnt_d     = '0;
              frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
              v_cnt_d = v_cnt_q + 10'd1;
            end
          end else begin
            h_cnt_d = h_cnt_q + 11'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Flags are decoded from the next counter values so they register in
    // the same cycle as the counters they describe.
    if (advance) begin
      hsync_d       = ((h_cnt_d >= HS_BEG) && (h_cnt_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = ((v_cnt_d >= VS_BEG) && (v_cnt_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
      video_on_d    = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
      line_end_d    = (h_cnt_d == H_LAST);
      frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rst_sync_q    <= 2'b11;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_cnt_q   <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_sync_q    <= rst_sync_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign count_rgb       = h_cnt_q;
  assign reset_count_rgb = v_cnt_q;
  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign video_on        = video_on_q;
  assign line_end        = line_end_q;
  assign frame_start     = frame_start_q;
  assign frame_count     = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-size instance for line timing, small-raster
// instances (both sync polarities) for frame wrap, gating and reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic pix_en_big;
  logic pix_en_sm;

  always #5 clk = ~clk;

  logic [10:0] b_count, s_count, i_count;
  logic [9:0]  b_line, s_line, i_line;
  logic        b_hsync, b_vsync, b_video_on, b_line_end, b_frame_start;
  logic        s_hsync, s_vsync, s_video_on, s_line_end, s_frame_start;
  logic        i_hsync, i_vsync, i_video_on, i_line_end, i_frame_start;
  logic [7:0]  b_fc, s_fc, i_fc;

  vga_timing_gen dut_big (
    .clk(clk), .rst(rst), .pix_en(pix_en_big),
    .count_rgb(b_count), .reset_count_rgb(b_line),
    .hsync(b_hsync), .vsync(b_vsync), .video_on(b_video_on),
    .line_end(b_line_end), .frame_start(b_frame_start), .frame_count(b_fc)
  );

  // Small raster: H = 8+2+3+2 = 15, V = 4+1+2+1 = 8, 120 pixels per frame.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_sm (
    .clk(clk), .rst(rst), .pix_en(pix_en_sm),
    .count_rgb(s_count), .reset_count_rgb(s_line),
    .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on),
    .line_end(s_line_end), .frame_start(s_frame_start), .frame_count(s_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_inv (
    .clk(clk), .rst(rst), .pix_en(pix_en_sm),
    .count_rgb(i_count), .reset_count_rgb(i_line),
    .hsync(i_hsync), .vsync(i_vsync), .video_on(i_video_on),
    .line_end(i_line_end), .frame_start(i_frame_start), .frame_count(i_fc)
  );

  wire [4:0] b_flags = {b_hsync, b_vsync, b_video_on, b_line_end, b_frame_start};
  wire [4:0] s_flags = {s_hsync, s_vsync, s_video_on, s_line_end, s_frame_start};
  wire [4:0] i_flags = {i_hsync, i_vsync, i_video_on, i_line_end, i_frame_start};

  int n_checks = 0;
  int n_errors = 0;

  int m_h, m_v, m_fc;
  logic [7:0] vs_mask;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {hsync, vsync, video_on, line_end, frame_start} for the small raster, active-high sync.
  function automatic logic [4:0] sm_flags(input int h, input int v);
    sm_flags = {(h >= 10 && h <= 12), (v >= 5 && v <= 6), (h < 8 && v < 4),
                (h == 14), (h == 0 && v == 0)};
  endfunction

  task automatic run_sm(input int n, input bit rnd, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      pix_en_sm = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (pix_en_sm) begin
        if (m_h == 14) begin
          m_h = 0;
          if (m_v == 7) begin
            m_v  = 0;
            m_fc = (m_fc + 1) % 256;
          end else begin
            m_v++;
          end
        end else begin
          m_h++;
        end
      end
      if (s_vsync) vs_mask[m_v] = 1'b1;
      if (s_count !== 11'(m_h) || s_line !== 10'(m_v) || s_fc !== 8'(m_fc) ||
          s_flags !== sm_flags(m_h, m_v)) bad++;
      if (i_count !== 11'(m_h) || i_line !== 10'(m_v) || i_fc !== 8'(m_fc) ||
          i_flags !== (sm_flags(m_h, m_v) ^ 5'b11000)) bad++;
    end
  endtask

  initial begin
    int bad, le_cnt, cycles;
    bit started;

    rst = 1'b0;
    pix_en_big = 1'b0;
    pix_en_sm  = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_async_big_count", b_count, 0);
    check("rst_async_big_flags", b_flags, 5'b00000);
    repeat (3) tick();
    check("rst_big_line", b_line, 0);
    check("rst_big_fc", b_fc, 0);
    check("rst_sm_flags", s_flags, 5'b00000);
    check("rst_inv_flags", i_flags, 5'b11000);

    // Release and idle with pix_en low: nothing may move.
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b_count !== 11'd0 || b_line !== 10'd0 || b_flags !== 5'b00000 || b_fc !== 8'd0) bad++;
    end
    check("idle_hold", bad, 0);

    pix_en_big = 1'b1;
    tick();
    check("start_count", b_count, 0);
    check("start_line", b_line, 0);
    check("start_flags", b_flags, 5'b00101);

    // One full line on the default raster.
    bad = 0;
    le_cnt = 0;
    for (int eh = 1; eh < 1040; eh++) begin
      tick();
      if (b_count !== 11'(eh) || b_line !== 10'd0) bad++;
      if (b_line_end) le_cnt++;
      if (eh == 799)  check("video_on_799", b_video_on, 1);
      if (eh == 800)  check("video_off_800", b_video_on, 0);
      if (eh == 855)  check("hsync_855", b_hsync, 0);
      if (eh == 856)  check("hsync_856", b_hsync, 1);
      if (eh == 975)  check("hsync_975", b_hsync, 1);
      if (eh == 976)  check("hsync_976", b_hsync, 0);
      if (eh == 1039) check("line_end_1039", b_line_end, 1);
    end
    check("line_seq", bad, 0);
    check("line_end_once", le_cnt, 1);
    tick();
    check("wrap_count", b_count, 0);
    check("wrap_line", b_line, 1);
    check("wrap_flags", b_flags, 5'b00100);

    pix_en_big = 1'b0;
    repeat (5) tick();
    check("hold_count", b_count, 0);
    check("hold_line", b_line, 1);
    check("hold_flags", b_flags, 5'b00100);

    // Small raster: entry, full frame, vsync window, frame wrap.
    pix_en_sm = 1'b1;
    tick();
    check("sm_start_count", s_count, 0);
    check("sm_start_flags", s_flags, 5'b00101);
    check("inv_start_flags", i_flags, 5'b11101);
    check("sm_start_fc", s_fc, 0);
    m_h = 0; m_v = 0; m_fc = 0;
    vs_mask = 8'h00;
    run_sm(119, 1'b0, bad);
    check("sm_frame_seq", bad, 0);
    check("sm_last_count", s_count, 14);
    check("sm_last_line", s_line, 7);
    check("vsync_lines", vs_mask, 8'h60);
    run_sm(1, 1'b0, bad);
    check("sm_wrap_seq", bad, 0);
    check("sm_wrap_fc", s_fc, 1);
    check("sm_wrap_fs", s_frame_start, 1);
    check("sm_wrap_count", s_count, 0);

    // Pseudo-random enable: model only advances on enabled edges.
    run_sm(300, 1'b1, bad);
    check("gated_seq", bad, 0);

    // Run to the 255th frame boundary, then wrap the frame counter.
    cycles = (255 * 120 + 119) - (m_fc * 120 + m_v * 15 + m_h);
    run_sm(cycles, 1'b0, bad);
    check("preload_seq", bad, 0);
    check("preload_fc", s_fc, 255);
    check("preload_count", s_count, 14);
    run_sm(1, 1'b0, bad);
    check("fc_wrap", s_fc, 0);
    check("fc_wrap_fs", s_frame_start, 1);

    // Mid-frame reset with frame_count = 3 at (5, 2).
    run_sm(3 * 120 + 2 * 15 + 5, 1'b0, bad);
    check("pre_rst_seq", bad, 0);
    check("pre_rst_fc", s_fc, 3);
    check("pre_rst_count", s_count, 5);
    check("pre_rst_line", s_line, 2);
    rst = 1'b1;
    #1;
    check("mid_rst_count", s_count, 0);
    check("mid_rst_line", s_line, 0);
    check("mid_rst_fc", s_fc, 0);
    check("mid_rst_flags", s_flags, 5'b00000);
    check("mid_rst_inv_flags", i_flags, 5'b11000);
    check("mid_rst_big_line", b_line, 0);
    check("mid_rst_big_flags", b_flags, 5'b00000);
    tick();
    rst = 1'b0;
    pix_en_sm = 1'b1;
    tick();
    check("no_start_edge1", s_frame_start, 0);
    started = 1'b0;
    for (int k = 0; k < 5 && !started; k++) begin
      if (s_frame_start) started = 1'b1;
      else tick();
    end
    if (!started && s_frame_start) started = 1'b1;
    check("restart_within_budget", started, 1);
    check("restart_count", s_count, 0);
    check("restart_line", s_line, 0);
    check("restart_fc", s_fc, 0);
    m_h = 0; m_v = 0; m_fc = 0;
    run_sm(40, 1'b0, bad);
    check("restart_seq", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
